// File: rtl/ln_fixed.sv
// Sequential natural logarithm: unsigned Q16.8 in, signed Q16.8 out.
// Normalise to m*2^k, extract log2(m) by repeated squaring, then scale by ln2.
module ln_fixed #(
    parameter int W         = 24,
    parameter int M         = 24,
    parameter int I_FRAC    = 8,
    parameter int FRAC_BITS = 12,
    parameter int LN2_Q16   = 45426
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         i_ce,
    input  logic         i_start,
    input  logic [W-1:0] i_val,
    output logic [M-1:0] o_ln,
    output logic         busy,
    output logic         done,
    output logic         error
);

    typedef enum logic [1:0] {IDLE, NORM, FRAC, SCALE} state_t;

    localparam int KW    = 6;                       // holds k in -8..15
    localparam int CW    = $clog2(FRAC_BITS + 1);
    localparam int LW    = KW + FRAC_BITS;
    localparam int PW    = LW + 18;
    localparam int SHIFT = FRAC_BITS + 16 - I_FRAC;

    localparam logic signed [KW-1:0] K_INIT = KW'(W - 1 - I_FRAC);
    localparam logic signed [PW-1:0] LN2_S  = PW'(LN2_Q16);

    state_t                 state_q, state_d;
    logic [W-1:0]           m_q, m_d;
    logic signed [KW-1:0]   k_q, k_d;
    logic [FRAC_BITS-1:0]   f_q, f_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [M-1:0]           o_ln_d;
    logic                   error_d, done_d;

    logic [W:0]             sq_top;
    logic signed [LW-1:0]   l_val;
    logic signed [PW-1:0]   prod;
    logic [M-1:0]           scaled;

    // Top W+1 bits of m*m (Q2.(2W-2)); bit W decides whether the square reached 2.
    assign sq_top = (W+1)'(({{W{1'b0}}, m_q} * {{W{1'b0}}, m_q}) >> (W - 1));

    // k in the integer bits and f as the fraction is exactly (k <<< FRAC_BITS) + f.
    assign l_val  = $signed({k_q, f_q});
    assign prod   = $signed({{(PW-LW){l_val[LW-1]}}, l_val}) * LN2_S;
    assign scaled = M'(prod >>> SHIFT);

    assign busy = (state_q != IDLE);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        m_d     = m_q;
        k_d     = k_q;
        f_d     = f_q;
        cnt_d   = cnt_q;
        o_ln_d  = o_ln;
        error_d = error;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    error_d = 1'b0;
                    if (i_val == '0) begin
                        error_d = 1'b1;
                        o_ln_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        m_d     = i_val;
                        k_d     = K_INIT;
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (!m_q[W-1]) begin
                    m_d = m_q << 1;
                    k_d = k_q - KW'(1);
                end else begin
                    cnt_d   = CW'(FRAC_BITS);
                    f_d     = '0;
                    state_d = FRAC;
                end
            end
            FRAC: begin
                m_d   = sq_top[W] ? sq_top[W:1] : sq_top[W-1:0];
                f_d   = {f_q[FRAC_BITS-2:0], sq_top[W]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = SCALE;
            end
            SCALE: begin
                o_ln_d  = scaled;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            m_q     <= '0;
            k_q     <= '0;
            f_q     <= '0;
            cnt_q   <= '0;
            o_ln    <= '0;
            error   <= 1'b0;
            done    <= 1'b0;
        end else begin
            // done is a pulse: it drops even on edges where the clock enable is low.
            done <= done_d & i_ce;
            if (i_ce) begin
                state_q <= state_d;
                m_q     <= m_d;
                k_q     <= k_d;
                f_q     <= f_d;
                cnt_q   <= cnt_d;
                o_ln    <= o_ln_d;
                error   <= error_d;
            end
        end
    end

endmodule

// File: tb/tb_ln_fixed.sv
// Self-checking bench for ln_fixed: fixed vectors, corner sequences and
// random operands against a real-valued ln() model with truncation tolerance.
module tb_ln_fixed;

    logic        CLK = 1'b0;
    logic        RST;
    logic        i_ce;
    logic        i_start;
    logic [23:0] i_val;
    logic [23:0] o_ln;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;

    ln_fixed dut (
        .CLK     (CLK),
        .RST     (RST),
        .i_ce    (i_ce),
        .i_start (i_start),
        .i_val   (i_val),
        .o_ln    (o_ln),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [23:0] val;
        int          lo;
        int          hi;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Latency counts edges after the accepting edge until done is seen high.
    task automatic run_op(input logic [23:0] v, input int ce_at, input int ce_len,
                          output int lat, output int res, output bit busy_ok);
        @(negedge CLK);
        i_val   = v;
        i_start = 1'b1;
        @(posedge CLK);
        #1;
        i_start = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!done && lat < 200) begin
            if (!busy) busy_ok = 1'b0;
            if (lat == ce_at) i_ce = 1'b0;
            if (lat == ce_at + ce_len) i_ce = 1'b1;
            @(posedge CLK);
            #1;
            lat++;
        end
        i_ce = 1'b1;
        check("done_seen", done, 1);
        res = int'($signed(o_ln));
    endtask

    function automatic int leading_zeros(input logic [23:0] v);
        for (int b = 23; b >= 0; b--)
            if (v[b]) return 23 - b;
        return 24;
    endfunction

    vec_t tbl[10];
    int   lat, res, n_done, hold_res;
    bit   busy_ok;

    initial begin
        tbl[0] = '{24'h000100,     0,     0, 29};
        tbl[1] = '{24'h000200,   177,   177, 28};
        tbl[2] = '{24'h000080,  -178,  -178, 30};
        tbl[3] = '{24'h0002B8,   255,   256, 28};
        tbl[4] = '{24'hFFFFFF,  2838,  2839, 14};
        tbl[5] = '{24'h000001, -1420, -1420, 37};
        tbl[6] = '{24'h800000,  2661,  2661, 14};
        tbl[7] = '{24'h000400,   354,   354, 27};
        tbl[8] = '{24'h000040,  -355,  -355, 31};
        tbl[9] = '{24'h010000,  1419,  1419, 21};

        // Reset held two cycles with a start request pending.
        RST = 1'b1; i_ce = 1'b1; i_start = 1'b1; i_val = 24'h000100;
        repeat (2) begin
            @(posedge CLK); #1;
            check("rst_o_ln", o_ln, 0);
            check("rst_done", done, 0);
            check("rst_error", error, 0);
            check("rst_busy", busy, 0);
        end
        RST = 1'b0; i_start = 1'b0;
        @(posedge CLK); #1;
        check("post_rst_idle", busy, 0);

        // Fixed vectors; consecutive ops also start in the cycle done is high.
        foreach (tbl[i]) begin
            run_op(tbl[i].val, -1, 0, lat, res, busy_ok);
            check_range("tbl_result", res, tbl[i].lo, tbl[i].hi);
            check("tbl_latency", lat, tbl[i].lat);
            check("tbl_busy_during", busy_ok, 1);
            check("tbl_busy_after", busy, 0);
            check("tbl_error", error, 0);
        end

        // Domain error, then recovery.
        run_op(24'h000200, -1, 0, lat, res, busy_ok);
        check("pre_err_result", res, 177);
        run_op(24'h000000, -1, 0, lat, res, busy_ok);
        check("err_flag", error, 1);
        check("err_result", res, 0);
        check("err_latency", lat, 0);
        repeat (3) @(posedge CLK);
        #1;
        check("err_hold", error, 1);
        run_op(24'h000100, -1, 0, lat, res, busy_ok);
        check("err_clear", error, 0);
        check("err_next_result", res, 0);

        // Start pulses while busy are ignored.
        @(negedge CLK);
        i_val = 24'h000200; i_start = 1'b1;
        @(posedge CLK); #1;
        n_done = 0; hold_res = 0;
        for (int c = 0; c < 40; c++) begin
            if (c < 10) begin
                i_start = c[0];
                i_val   = 24'h000000;
            end else begin
                i_start = 1'b0;
            end
            @(posedge CLK); #1;
            if (done) begin
                n_done++;
                hold_res = int'($signed(o_ln));
            end
        end
        check("busy_start_dones", n_done, 1);
        check("busy_start_result", hold_res, 177);
        check("busy_start_error", error, 0);

        // Clock enable low for 5 cycles during FRAC.
        run_op(24'h000200, 18, 5, lat, res, busy_ok);
        check("ce_latency", lat, 33);
        check("ce_result", res, 177);

        // Reset during NORM aborts without a done pulse.
        @(negedge CLK);
        i_val = 24'h000001; i_start = 1'b1;
        @(posedge CLK); #1;
        i_start = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_o_ln", o_ln, 0);
        n_done = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run_op(24'h000080, -1, 0, lat, res, busy_ok);
        check("abort_recover", res, -178);

        // Random operands of random magnitude against real ln().
        for (int n = 0; n < 40; n++) begin
            logic [23:0] v;
            real         t;
            int          w;
            w = $urandom_range(1, 24);
            v = 24'($urandom) & 24'((32'd1 << w) - 1);
            if (v == 24'd0) v = 24'd1;
            run_op(v, -1, 0, lat, res, busy_ok);
            t = $ln(real'(v) / 256.0) * 256.0;
            // Truncated log2 bits and truncated ln2 only ever pull the result down slightly.
            check_range("rand_result", res, int'($floor(t - 0.5)), int'($floor(t + 0.02)));
            check("rand_latency", lat, leading_zeros(v) + 14);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
